// File: rtl/alu_issue_ctrl.sv
// Issue controller for a fixed-latency external ALU. It registers one request
// onto the ALU operand bus, captures the result ALU_LAT cycles later, and holds it until the consumer takes it.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ALU_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_carry,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_fsec,
  output logic              alu_carry,
  input  logic [DATA_W-1:0] alu_fout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_neg,
  output logic              rsp_err,
  output logic [15:0]       op_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [4:0] {
    OP_ADD, OP_ADDC, OP_SUBBA, OP_SUBAB, OP_INC, OP_DEC, OP_SHL1, OP_SHR1
  } op_t;

  localparam logic [3:0] LAST_CNT = 4'(ALU_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       accept, legal, lat_done, rsp_hs;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  // Legal opcodes occupy exactly the 00xxx block.
  assign legal     = (req_op[4:3] == 2'b00);
  assign lat_done  = (state == WAIT) && (cnt == LAST_CNT);
  assign rsp_hs    = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = legal ? WAIT : RESP;
      WAIT: if (lat_done) state_nxt = RESP;
      RESP: if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (accept)          cnt <= '0;
    else if (state == WAIT)   cnt <= cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fsec  <= '0;
      alu_carry <= 1'b0;
    end else if (accept) begin
      alu_a     <= req_a;
      alu_b     <= req_b;
      alu_fsec  <= req_op;
      alu_carry <= (req_op == OP_ADDC) ? req_carry : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (accept && !legal) begin
      rsp_data <= '0;
      rsp_zero <= 1'b1;
      rsp_neg  <= 1'b0;
      rsp_err  <= 1'b1;
    end else if (lat_done) begin
      rsp_data <= alu_fout;
      rsp_zero <= (alu_fout == '0);
      rsp_neg  <= alu_fout[DATA_W-1];
      rsp_err  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         op_count <= '0;
    else if (rsp_hs) op_count <= op_count + 16'd1;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter DATA_W, default 64, operand/result width.
REQ-002 Parameter ALU_LAT, default 2, cycles from operands stable to ALU result sampled; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_op  input  5  operation code.
REQ-008 req_a  input  DATA_W  operand A.
REQ-009 req_b  input  DATA_W  operand B.
REQ-010 req_carry  input  1  carry-in for ADDC.
REQ-011 alu_a, alu_b  output  DATA_W each  operands driven to ALU.
REQ-012 alu_fsec  output  5  ALU function select.
REQ-013 alu_carry  output  1  ALU carry-in.
REQ-014 alu_fout  input  DATA_W  ALU result.
REQ-015 rsp_valid  output  1  response present.
REQ-016 rsp_ready  input  1  consumer accepts response.
REQ-017 rsp_data  output  DATA_W  captured result.
REQ-018 rsp_zero, rsp_neg, rsp_err  output  1 each  result==0, result MSB, illegal opcode.
REQ-019 op_count  output  16  count of completed responses.

Function
REQ-020 Legal opcodes SHALL be: 00000 ADD, 00001 ADDC, 00010 SUBBA (B-A), 00011 SUBAB (A-B), 00100 INC, 00101 DEC, 00110 SHL1, 00111 SHR1; all others illegal.
REQ-021 States SHALL be IDLE, WAIT, RESP; req_ready=1 only in IDLE, rsp_valid=1 only in RESP.
REQ-022 Accept = req_valid&&req_ready at edge E0; at E0 req_a/req_b/req_op/req_carry SHALL be registered onto alu_a/alu_b/alu_fsec/alu_carry.
REQ-023 Legal accept: IDLE->WAIT with wait counter cleared to 0; counter increments each WAIT cycle.
REQ-024 In WAIT, at the edge where counter==ALU_LAT-1 (edge E0+ALU_LAT), alu_fout SHALL be captured into rsp_data, flags computed from captured value, rsp_err=0, state->RESP.
REQ-025 Illegal accept: IDLE->RESP at E0, rsp_data=0, rsp_zero=1, rsp_neg=0, rsp_err=1; alu_* outputs SHALL still update per REQ-022.
REQ-026 alu_carry SHALL equal req_carry for ADDC and 0 for all other opcodes.
REQ-027 alu_a/alu_b/alu_fsec/alu_carry SHALL hold constant from E0 until next accept.
REQ-028 In RESP, rsp_data and flags SHALL hold stable while rsp_ready=0; no timeout.
REQ-029 rsp_valid&&rsp_ready SHALL move RESP->IDLE and increment op_count (mod 2^16, wraps 0xFFFF->0x0000), including error responses.
REQ-030 No request is accepted in the cycle of a response handshake; minimum spacing between accepts is ALU_LAT+2 cycles.
REQ-031 req_valid while not in IDLE SHALL be ignored (no capture, no side effect).
REQ-032 rsp_zero = (rsp_data==0); rsp_neg = rsp_data[DATA_W-1].

Reset
REQ-033 rst=1 at an edge SHALL force state IDLE, counter 0, and all outputs 0 except req_ready=1, overriding any other event that edge.
REQ-034 Reset in WAIT or RESP SHALL discard the in-flight operation; no response is produced and op_count is cleared.
REQ-035 First accept is possible at the first edge with rst=0.

Verification
REQ-036 ADD A=5,B=7, ALU_LAT=2, rsp_ready=1 -> alu_fsec=00000 after E0, rsp_valid high after E0+2, rsp_data=12, zero=0, neg=0, op_count=1.
REQ-037 ADDC A=0xFFFF_FFFF_FFFF_FFFF,B=0,carry=1 -> alu_carry=1, rsp_data=0, rsp_zero=1; SUBAB with carry=1 -> alu_carry=0.
REQ-038 SUBAB A=3,B=5 -> rsp_data=0xFFFF_FFFF_FFFF_FFFE, rsp_neg=1; rsp_ready held 0 for 10 cycles -> rsp_valid and data stable, req_ready=0, extra req_valid ignored.
REQ-039 Opcode 11111 -> rsp_valid one cycle after accept, rsp_err=1, rsp_data=0; op_count increments on handshake.
REQ-040 rst asserted in WAIT cycle 1 -> next cycle IDLE, req_ready=1, rsp_valid=0, all outputs 0, op_count=0, no response ever emitted.
REQ-041 Preload 65535 handshakes -> next handshake wraps op_count to 0x0000.
